mem_port_arbiter: RTL

Shares the single-port instruction/data RAM between the fetch stage (instruction reads) and the memory stage (LDR reads / STR writes). It grants one requester per cycle, routes the 1-cycle-latency read data back to its owner, and drives fetch stalls. It also sequences boot and halt: no access in the boot cycle, and a drain followed by a sticky halt after the memory stage signals halt.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/arb_starve_ctr.sv | 35 +++
 rtl/mem_port_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and default widths for the RAM port arbiter
package mem_arb_pkg;

  localparam int DEF_ADDR_W     = 7;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_STARVE_MAX = 4;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    DRAIN,
    HALTED
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_DATA
  } owner_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// rtl/arb_starve_ctr.sv - saturating count of consecutive denied fetch cycles
module arb_starve_ctr #(
  parameter int MAX = 4,
  localparam int W = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !sat) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat = (cnt_q == W'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for the shared single-port RAM
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt_req,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              stall_fetch,
  output logic              halted
);

  arb_state_t state_q, state_d;
  owner_t     owner_q, owner_d;
  logic       starve_sat;
  logic       d_wins;

  arb_starve_ctr #(
    .MAX(STARVE_MAX)
  ) u_starve (
    .clk(clk),
    .rst(rst),
    .inc(if_req & ~if_gnt),
    .clr(~if_req | if_gnt),
    .sat(starve_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      owner_q <= OWN_NONE;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = halt_req ? DRAIN : RUN;
      RUN:     state_d = halt_req ? DRAIN : RUN;
      DRAIN:   state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = BOOT;
    endcase
  end

  // Data only loses to fetch once fetch has been starved STARVE_MAX cycles.
  assign d_wins = d_req && (!starve_sat || !if_req);

  always_comb begin
    if_gnt      = 1'b0;
    d_gnt       = 1'b0;
    if (!rst && state_q == RUN) begin
      if (d_wins) begin
        d_gnt = 1'b1;
      end else if (if_req && !halt_req) begin
        if_gnt = 1'b1;
      end
    end

    owner_d = OWN_NONE;
    if (if_gnt) begin
      owner_d = OWN_IF;
    end else if (d_gnt && !d_we) begin
      owner_d = OWN_DATA;
    end

    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (if_gnt) begin
      ram_addr = if_addr;
    end else if (d_gnt) begin
      ram_addr = d_addr;
      if (d_we) begin
        ram_we    = 1'b1;
        ram_wdata = d_wdata;
      end
    end

    // Gating with rst drops a read return that was still in flight.
    if_rvalid   = !rst && owner_q == OWN_IF;
    d_rvalid    = !rst && owner_q == OWN_DATA;
    if_rdata    = if_rvalid ? ram_rdata : '0;
    d_rdata     = d_rvalid ? ram_rdata : '0;
    stall_fetch = !rst && if_req && !if_gnt;
    halted      = !rst && state_q == HALTED;
  end

endmodule
